// File: rtl/cmos_frame_rx.sv
// CMOS video sink: rebuilds pixel X/Y from VSYNC/HREF/CLKEN and re-emits pixels with sof/line markers.
// Checks each frame's geometry and reports a status, a running frame count and a data checksum.
module cmos_frame_rx #(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int DATA_W    = 24,
  parameter int POS_W     = 11,
  parameter int VSYNC_POL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CMOS_VSYNC,
  input  logic              CMOS_HREF,
  input  logic              CMOS_CLKEN,
  input  logic [DATA_W-1:0] CMOS_DATA,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  output logic [POS_W-1:0]  pix_x,
  output logic [POS_W-1:0]  pix_y,
  output logic              sof,
  output logic              line_done,
  output logic              frame_done,
  output logic              frame_ok,
  output logic              err_hlen,
  output logic              err_vlen,
  output logic [15:0]       frame_cnt,
  output logic [31:0]       checksum
);

  localparam logic [POS_W-1:0] HDISP = POS_W'(IMG_HDISP);
  localparam logic [POS_W-1:0] VDISP = POS_W'(IMG_VDISP);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ACTIVE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_vs_q;
  logic               r_href_q;
  logic [POS_W-1:0]   r_x;
  logic [POS_W-1:0]   r_y;
  logic               r_hlen;
  logic [31:0]        r_sum;

  logic               w_vs_n;
  logic               w_bnd;
  logic               w_acc;
  logic               w_line_end;
  logic               w_run;
  logic               w_report;
  logic               w_take;
  logic               w_emit;
  logic               w_close;
  logic               w_hlen_fin;
  logic [POS_W-1:0]   w_x_new;
  logic [POS_W-1:0]   w_y_fin;
  logic [31:0]        w_sum_fin;

  always_comb begin
    w_vs_n     = (VSYNC_POL != 0) ? CMOS_VSYNC : !CMOS_VSYNC;
    w_bnd      = w_vs_n && !r_vs_q;
    w_acc      = CMOS_HREF && CMOS_CLKEN;
    w_line_end = r_href_q && !CMOS_HREF;
    w_run      = (r_state != S_IDLE);
    w_report   = (r_state == S_ACTIVE) && w_bnd;
    // A pixel on the boundary cycle still belongs to the closing frame; in ARMED it is dropped.
    w_take     = w_acc && ((r_state == S_ACTIVE) || ((r_state == S_ARMED) && !w_bnd));
    w_emit     = w_take && (r_x < HDISP) && (r_y < VDISP);
    w_x_new    = (w_take && (r_x != '1)) ? r_x + POS_W'(1) : r_x;
    // Lines close on HREF falling, or at a reporting boundary while HREF is still high.
    w_close    = w_run && (w_line_end || (w_report && CMOS_HREF)) && (w_x_new != '0);
    w_hlen_fin = r_hlen || (w_close && (w_x_new != HDISP));
    w_y_fin    = (w_close && (r_y != '1)) ? r_y + POS_W'(1) : r_y;
    w_sum_fin  = r_sum + (w_emit ? 32'(CMOS_DATA) : 32'd0);

    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_bnd) w_state_nxt = S_ARMED;
      S_ARMED:  if (!w_bnd && w_acc) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (w_bnd) w_state_nxt = S_ARMED;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs_q   <= 1'b0;
      r_href_q <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_hlen   <= 1'b0;
      r_sum    <= '0;
    end else begin
      r_vs_q   <= w_vs_n;
      r_href_q <= CMOS_HREF;
      if (w_bnd) begin
        r_x    <= '0;
        r_y    <= '0;
        r_hlen <= 1'b0;
        r_sum  <= '0;
      end else begin
        r_x    <= w_close ? '0 : w_x_new;
        r_y    <= w_y_fin;
        r_hlen <= w_hlen_fin;
        r_sum  <= w_sum_fin;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      sof        <= 1'b0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      err_hlen   <= 1'b0;
      err_vlen   <= 1'b0;
      frame_cnt  <= '0;
      checksum   <= '0;
    end else begin
      pix_valid  <= w_emit;
      sof        <= w_emit && (r_state == S_ARMED);
      line_done  <= w_close;
      frame_done <= w_report;
      if (w_emit) begin
        pix_data <= CMOS_DATA;
        pix_x    <= r_x;
        pix_y    <= r_y;
      end
      if (w_report) begin
        err_hlen  <= w_hlen_fin;
        err_vlen  <= (w_y_fin != VDISP);
        frame_ok  <= !w_hlen_fin && (w_y_fin == VDISP);
        checksum  <= w_sum_fin;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_cmos_frame_rx.sv
// Bench for cmos_frame_rx: an active-high and an active-low VSYNC instance driven with the same
// stream, checked against a per-frame reference model plus a table of hand-computed frame results.
module tb_cmos_frame_rx;
  localparam int H  = 8;
  localparam int V  = 4;
  localparam int DW = 24;
  localparam int PW = 11;

  logic clk = 1'b0, rst = 1'b1, vs = 1'b0, href = 1'b0, clken = 1'b0;
  logic [DW-1:0] data = '0;
  logic vs_l;
  assign vs_l = ~vs;

  logic [1:0]         pv, so, ld, fd, fok, eh, ev;
  logic [1:0][DW-1:0] pd;
  logic [1:0][PW-1:0] px, py;
  logic [1:0][15:0]   fc;
  logic [1:0][31:0]   cs;

  cmos_frame_rx #(.IMG_HDISP(H), .IMG_VDISP(V), .DATA_W(DW), .POS_W(PW), .VSYNC_POL(1)) dut_hi (
    .clk(clk), .rst(rst), .CMOS_VSYNC(vs), .CMOS_HREF(href), .CMOS_CLKEN(clken), .CMOS_DATA(data),
    .pix_valid(pv[0]), .pix_data(pd[0]), .pix_x(px[0]), .pix_y(py[0]), .sof(so[0]),
    .line_done(ld[0]), .frame_done(fd[0]), .frame_ok(fok[0]), .err_hlen(eh[0]), .err_vlen(ev[0]),
    .frame_cnt(fc[0]), .checksum(cs[0]));

  cmos_frame_rx #(.IMG_HDISP(H), .IMG_VDISP(V), .DATA_W(DW), .POS_W(PW), .VSYNC_POL(0)) dut_lo (
    .clk(clk), .rst(rst), .CMOS_VSYNC(vs_l), .CMOS_HREF(href), .CMOS_CLKEN(clken), .CMOS_DATA(data),
    .pix_valid(pv[1]), .pix_data(pd[1]), .pix_x(px[1]), .pix_y(py[1]), .sof(so[1]),
    .line_done(ld[1]), .frame_done(fd[1]), .frame_ok(fok[1]), .err_hlen(eh[1]), .err_vlen(ev[1]),
    .frame_cnt(fc[1]), .checksum(cs[1]));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  typedef struct packed {
    logic [PW-1:0] x;
    logic [PW-1:0] y;
    logic [DW-1:0] d;
    logic          sof;
  } pix_t;

  typedef struct packed {
    logic        ok, h, v;
    logic [31:0] sum;
    logic [15:0] cnt;
  } rep_t;

  typedef struct {
    int          nl;
    int          sy;
    int          sl;
    int          gap;
    bit          bnd;
    logic        ok, h, v;
    logic [31:0] sum;
  } row_t;

  pix_t exp_pix[$];
  rep_t exp_rep[$];
  int   prd[2], rrd[2], nld[2];

  // Reference model: tracks the frame as "lines of accepted pixels", not as receiver state.
  bit          m_open, m_first, m_hbad;
  int          m_x, m_lines, m_nld;
  logic [31:0] m_sum;
  logic [15:0] m_cnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic m_clear();
    m_first = 1'b1; m_x = 0; m_lines = 0; m_hbad = 1'b0; m_sum = '0;
  endtask

  task automatic m_reset();
    m_open = 1'b0; m_cnt = '0;
    m_clear();
  endtask

  task automatic m_pixel(input logic [DW-1:0] d);
    pix_t p;
    if (!m_open) return;
    if (m_x < H && m_lines < V) begin
      p.x = PW'(m_x); p.y = PW'(m_lines); p.d = d; p.sof = m_first;
      exp_pix.push_back(p);
      m_sum += 32'(d);
    end
    m_first = 1'b0;
    m_x++;
  endtask

  task automatic m_line_end();
    if (!m_open) return;
    if (m_x > 0) begin
      m_lines++;
      m_nld++;
      if (m_x != H) m_hbad = 1'b1;
    end
    m_x = 0;
  endtask

  task automatic m_boundary();
    rep_t r;
    if (m_open && !m_first) begin
      m_line_end();
      m_cnt++;
      r.h = m_hbad; r.v = (m_lines != V); r.ok = !r.h && !r.v;
      r.sum = m_sum; r.cnt = m_cnt;
      exp_rep.push_back(r);
    end
    m_open = 1'b1;
    m_clear();
  endtask

  task automatic mon(input int d);
    pix_t e, a;
    rep_t er;
    if (pv[d]) begin
      if (prd[d] < exp_pix.size()) begin
        e = exp_pix[prd[d]];
        a = {px[d], py[d], pd[d], so[d]};
        chk($sformatf("pixel dut%0d #%0d {x,y,data,sof}", d, prd[d]), 64'(a), 64'(e));
      end else begin
        chk($sformatf("unexpected pixel count dut%0d", d), prd[d] + 1, exp_pix.size());
      end
      prd[d]++;
    end
    if (ld[d]) nld[d]++;
    if (fd[d]) begin
      if (rrd[d] < exp_rep.size()) begin
        er = exp_rep[rrd[d]];
        chk($sformatf("report dut%0d #%0d {ok,hlen,vlen}", d, rrd[d]), {fok[d], eh[d], ev[d]}, {er.ok, er.h, er.v});
        chk($sformatf("report dut%0d #%0d checksum", d, rrd[d]), cs[d], er.sum);
        chk($sformatf("report dut%0d #%0d frame_cnt", d, rrd[d]), fc[d], er.cnt);
      end else begin
        chk($sformatf("unexpected report count dut%0d", d), rrd[d] + 1, exp_rep.size());
      end
      rrd[d]++;
    end
  endtask

  always @(negedge clk) if (!rst) begin mon(0); mon(1); end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic vsync_pulse();
    vs = 1'b1; m_boundary();
    repeat (3) tick();
    vs = 1'b0;
    repeat (3) tick();
  endtask

  // gap: 0 none, 1 one CLKEN-low cycle before every pixel, 2 random 0..2 idle cycles.
  task automatic drive_line(input int y, input int n, input int gap, input bit rnd, input bit bnd_end);
    int g;
    logic [DW-1:0] d;
    href = 1'b1;
    for (int i = 0; i < n; i++) begin
      g = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (g) begin clken = 1'b0; data = DW'($urandom); tick(); end
      d = rnd ? DW'($urandom) : DW'(y * 8 + i);
      clken = 1'b1; data = d; m_pixel(d);
      if (bnd_end && i == n - 1) begin vs = 1'b1; m_boundary(); end
      tick();
    end
    clken = 1'b0;
    if (bnd_end) repeat (2) tick();
    href = 1'b0; m_line_end(); tick();
    repeat (3) begin clken = 1'($urandom); data = DW'($urandom); tick(); end
    if (bnd_end) begin vs = 1'b0; repeat (3) tick(); end
  endtask

  task automatic drive_frame(input row_t r);
    for (int li = 0; li < r.nl; li++)
      drive_line(li, (li == r.sy) ? r.sl : H, r.gap, 1'b0, r.bnd && (li == r.nl - 1));
  endtask

  row_t tbl[6];

  initial begin
    int nl, gp;
    bit bd;
    // nl, short line, its length, gap mode, boundary on last pixel, ok, hlen, vlen, checksum
    tbl[0] = '{4, -1, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd496};
    tbl[1] = '{4,  2, 7, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd473};
    tbl[2] = '{5, -1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd496};
    tbl[3] = '{4, -1, 0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd496};
    tbl[4] = '{4,  3, 5, 0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd406};
    tbl[5] = '{4, -1, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd496};
    m_nld = 0;
    for (int d = 0; d < 2; d++) begin prd[d] = 0; rrd[d] = 0; nld[d] = 0; end
    m_reset();

    repeat (3) tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset strobes/status dut%0d", d), {pv[d], so[d], ld[d], fd[d], fok[d], eh[d], ev[d]}, '0);
      chk($sformatf("reset frame_cnt dut%0d", d), fc[d], '0);
      chk($sformatf("reset checksum dut%0d", d), cs[d], '0);
      chk($sformatf("reset pixel regs dut%0d", d), {pd[d], px[d], py[d]}, '0);
    end
    tick();
    rst = 1'b0;
    repeat (2) tick();

    vsync_pulse();
    for (int i = 0; i < 6; i++) begin
      drive_frame(tbl[i]);
      if (!tbl[i].bnd) vsync_pulse();
      repeat (3) tick();
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("row%0d dut%0d {ok,hlen,vlen}", i, d), {fok[d], eh[d], ev[d]}, {tbl[i].ok, tbl[i].h, tbl[i].v});
        chk($sformatf("row%0d dut%0d checksum", i, d), cs[d], tbl[i].sum);
        chk($sformatf("row%0d dut%0d frame_cnt", i, d), fc[d], i + 1);
      end
    end

    for (int f = 0; f < 8; f++) begin
      nl = $urandom_range(3, 5);
      bd = 1'($urandom_range(0, 1));
      gp = $urandom_range(0, 2);
      for (int li = 0; li < nl; li++)
        drive_line(li, ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 10)) : H, gp, 1'b1, bd && (li == nl - 1));
      if (!bd) vsync_pulse();
    end
    repeat (4) tick();

    rst = 1'b1; m_reset();
    repeat (2) tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("mid reset frame_cnt dut%0d", d), fc[d], '0);
      chk($sformatf("mid reset frame_ok dut%0d", d), fok[d], '0);
    end
    href = 1'b1;
    for (int i = 0; i < 6; i++) begin
      clken = 1'b1; data = DW'($urandom); m_pixel(data);
      if (i == 3) rst = 1'b0;
      tick();
    end
    href = 1'b0; m_line_end(); tick();
    drive_line(1, H, 0, 1'b1, 1'b0);
    vsync_pulse();
    for (int f = 0; f < 2; f++) begin
      for (int li = 0; li < V; li++) drive_line(li, H, 0, 1'b1, 1'b0);
      vsync_pulse();
    end
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("post reset frame_cnt dut%0d", d), fc[d], 2);
      chk($sformatf("post reset frame_ok dut%0d", d), fok[d], 1);
    end

    repeat (4) tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("pixels delivered dut%0d", d), prd[d], exp_pix.size());
      chk($sformatf("reports delivered dut%0d", d), rrd[d], exp_rep.size());
      chk($sformatf("line_done pulses dut%0d", d), nld[d], m_nld);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cmos_frame_rx.md
Name: cmos_frame_rx

Overview:
- Sink end of the CMOS-style video stream (VSYNC/HREF/CLKEN/DATA) produced by the team's sim_cmos source.
- Rebuilds pixel X/Y positions independently of the source and re-emits pixels with sof and line-done markers.
- Checks each frame's geometry against IMG_HDISP x IMG_VDISP and reports per-frame status, frame count and data checksum.
- Used in stitching benches and on-chip as the capture front end ahead of line buffers.

Parameters:
- IMG_HDISP, 640: expected pixels per line.
- IMG_VDISP, 480: expected lines per frame.
- DATA_W, 24: pixel width (RGB888).
- POS_W, 11: width of the X/Y position counters; must satisfy 2^POS_W > max(IMG_HDISP, IMG_VDISP).
- VSYNC_POL, 1: 1 = VSYNC active high, 0 = active low.

Ports:
- clk  in  1  pixel clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- CMOS_VSYNC  in  1  frame sync; its assertion edge marks a frame boundary.
- CMOS_HREF  in  1  line-active window.
- CMOS_CLKEN  in  1  pixel qualifier; a pixel is accepted when HREF && CLKEN.
- CMOS_DATA  in  DATA_W  pixel data.
- pix_valid  out  1  registered pixel strobe.
- pix_data  out  DATA_W  registered pixel.
- pix_x  out  POS_W  column of pix_data.
- pix_y  out  POS_W  row of pix_data.
- sof  out  1  high with pix_valid for pixel (0,0) of a frame.
- line_done  out  1  one-cycle pulse after each line ends.
- frame_done  out  1  one-cycle pulse when a frame result is reported.
- frame_ok  out  1  status of the last reported frame; held until the next report.
- err_hlen  out  1  last reported frame had at least one line with pixel count != IMG_HDISP.
- err_vlen  out  1  last reported frame had line count != IMG_VDISP.
- frame_cnt  out  16  number of frames reported since reset; wraps.
- checksum  out  32  mod-2^32 sum of all accepted in-range pixels of the last reported frame.

Behaviour:
- Reset: the clock and reset are as stated above. Every output is 0. State goes to IDLE. All counters and accumulators are cleared.
- Input registering:
  - VSYNC is normalised by VSYNC_POL, then registered once.
  - The boundary edge is vs_n && !vs_q.
  - A line end is detected as HREF falling, using a registered HREF.
- States:
  - IDLE: waiting for sync. Pixels are ignored; a partial frame after reset is never reported. A boundary edge moves to ARMED.
  - ARMED: the first accepted pixel moves to ACTIVE. A boundary edge stays in ARMED with no report.
  - ACTIVE: receiving the frame. A boundary edge triggers a report and moves to ARMED.
- Pixel path, latency 1 cycle:
  - An accepted pixel with x < IMG_HDISP and y < IMG_VDISP drives pix_valid=1 next cycle, with pix_data, pix_x = x and pix_y = y.
  - The pixel is added to the running sum.
  - Out-of-range pixels advance the counters but are not emitted or summed.
- Counters:
  - x increments per accepted pixel and saturates at 2^POS_W-1.
  - At line end: compare x to IMG_HDISP and set a sticky hlen flag on mismatch. Then x=0, y increments (saturating), and line_done pulses next cycle.
  - A line with zero accepted pixels does not count as a line.
- sof = pix_valid for the first accepted pixel after entering ACTIVE.
- Report at a boundary edge in ACTIVE:
  - If HREF is still high with x>0, that partial line is closed first (hlen check, y increment).
  - On the next cycle: frame_done=1; err_hlen=sticky flag; err_vlen=(y != IMG_VDISP); frame_ok = !err_hlen && !err_vlen; checksum = running sum; frame_cnt increments.
  - x, y, the sticky flag and the sum are then cleared.
- A pixel accepted in the same cycle as a boundary edge belongs to the closing frame.
- Reset mid-frame aborts with no report and returns to IDLE.

Test Plan:
- IMG_HDISP=8, IMG_VDISP=4, data = y*8+x, bounded by two VSYNC pulses -> 32 pix_valid with correct x/y; sof once at (0,0); 4 line_done pulses; frame_done with frame_ok=1, checksum=496, frame_cnt=1.
- Same frame with line 2 carrying 7 pixels -> err_hlen=1, err_vlen=0, frame_ok=0, checksum = 496 minus the missing pixel value.
- Frame of 5 lines -> err_vlen=1; the 5th line is not emitted or summed; checksum=496.
- CLKEN toggling every other cycle inside HREF -> only qualified pixels counted; results identical to scenario 1.
- Release rst mid-frame, then feed 2 full frames -> no report for the partial frame; frame_cnt=2 after the second VSYNC pulse following the full frames; frame_ok=1 for both.
- VSYNC_POL=0 with an active-low VSYNC, plus a boundary edge arriving while HREF is high on the last line -> that line is closed, then frame_done; status matches pixels delivered.
